if_id_unit: RTL

- Fetch/decode stage feeding the multi-cycle control unit. Holds PC, PC0 (the address of the current instruction) and IR.
- Latches the instruction from instruction memory and decodes IR into the IS_* class flags, ALU_OP, register addresses and the immediate.
- Computes the next PC from the control unit's PC_Write, PC0_Write, IR_Write and PC_s strobes.
- Instruction memory has a parameterised latency; a busy flag marks fetches that are still in flight.

---
 rtl/if_id_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/if_id_unit.sv
// Fetch/decode stage: PC, PC0 and IR registers, next-PC select, latency-aware imem fetch and decode.
// Optional IF_MISALIGN_CHK_EN: PC_s=01/10 targets with bit1 set are refused and flagged in a sticky misalign_err.
module if_id_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 6,
  parameter int          IMEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_Write,
  input  logic              PC0_Write,
  input  logic              IR_Write,
  input  logic [1:0]        PC_s,
  input  logic [31:0]       rs1_data,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              fetch_busy,
  output logic [31:0]       PC,
  output logic [31:0]       PC0,
  output logic [31:0]       IR,
  output logic              IS_R,
  output logic              IS_IMM,
  output logic              IS_LUI,
  output logic              IS_LW,
  output logic              IS_SW,
  output logic              IS_BEQ,
  output logic              IS_JALR,
  output logic              IS_JAL,
  output logic [3:0]        ALU_OP,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       imm,
  output logic              illegal,
  output logic              misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] tgt_rel, tgt_jalr, pc_next;

  assign opcode = IR[6:0];
  assign f3     = IR[14:12];
  assign f7b    = IR[30];
  assign rs1    = IR[19:15];
  assign rs2    = IR[24:20];
  assign rd     = IR[11:7];

  assign imm_i = {{20{IR[31]}}, IR[31:20]};
  assign imm_s = {{20{IR[31]}}, IR[31:25], IR[11:7]};
  assign imm_b = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
  assign imm_u = {IR[31:12], 12'b0};
  assign imm_j = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};

  always_comb begin
    IS_R    = 1'b0;
    IS_IMM  = 1'b0;
    IS_LUI  = 1'b0;
    IS_LW   = 1'b0;
    IS_SW   = 1'b0;
    IS_BEQ  = 1'b0;
    IS_JALR = 1'b0;
    IS_JAL  = 1'b0;
    ALU_OP  = 4'b0000;
    imm     = 32'd0;
    case (opcode)
      7'b0110011: begin
        IS_R   = 1'b1;
        ALU_OP = {f7b, f3};
      end
      7'b0010011: begin
        IS_IMM = 1'b1;
        // Only the shift-right group uses bit 30 to pick arithmetic vs logical.
        ALU_OP = (f3 == 3'b101) ? {f7b, f3} : {1'b0, f3};
        imm    = imm_i;
      end
      7'b0110111: begin
        IS_LUI = 1'b1;
        imm    = imm_u;
      end
      7'b0000011: if (f3 == 3'b010) begin
        IS_LW = 1'b1;
        imm   = imm_i;
      end
      7'b0100011: if (f3 == 3'b010) begin
        IS_SW = 1'b1;
        imm   = imm_s;
      end
      7'b1100011: if (f3 == 3'b000) begin
        IS_BEQ = 1'b1;
        imm    = imm_b;
      end
      7'b1100111: if (f3 == 3'b000) begin
        IS_JALR = 1'b1;
        imm     = imm_i;
      end
      7'b1101111: begin
        IS_JAL = 1'b1;
        imm    = imm_j;
      end
      default: ;
    endcase
    illegal = ~(IS_R | IS_IMM | IS_LUI | IS_LW | IS_SW | IS_BEQ | IS_JALR | IS_JAL);
  end

  assign tgt_rel  = PC0 + imm;
  assign tgt_jalr = (rs1_data + imm) & ~32'd1;

`ifdef IF_MISALIGN_CHK_EN
  logic target_bad;

  always_comb begin
    pc_next    = PC;
    target_bad = 1'b0;
    case (PC_s)
      2'b00:   pc_next = PC + 32'd4;
      2'b01:   begin pc_next = tgt_rel;  target_bad = tgt_rel[1];  end
      2'b10:   begin pc_next = tgt_jalr; target_bad = tgt_jalr[1]; end
      default: pc_next = PC;
    endcase
    if (target_bad) pc_next = PC;
  end

  always_ff @(posedge clk) begin
    if (rst)                         misalign_err <= 1'b0;
    else if (PC_Write && target_bad) misalign_err <= 1'b1;
  end
`else
  always_comb begin
    pc_next = PC;
    case (PC_s)
      2'b00:   pc_next = PC + 32'd4;
      2'b01:   pc_next = tgt_rel;
      2'b10:   pc_next = tgt_jalr;
      default: pc_next = PC;
    endcase
  end

  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      PC  <= PC_RESET;
      PC0 <= 32'd0;
    end else begin
      if (PC_Write)  PC  <= pc_next;
      if (PC0_Write) PC0 <= PC;
    end
  end

  generate
    if (IMEM_LAT == 0) begin : g_comb_fetch
      assign fetch_busy = 1'b0;
      assign imem_addr  = PC[ADDR_W+1:2];

      always_ff @(posedge clk) begin
        if (rst)           IR <= NOP;
        else if (IR_Write) IR <= imem_rdata;
      end
    end else begin : g_lat_fetch
      typedef enum logic {S_IDLE, S_WAIT} fetch_state_t;
      fetch_state_t      state;
      logic [2:0]        cnt;
      logic [ADDR_W-1:0] fa;
      logic              busy;

      assign fetch_busy = busy;
      // The address is frozen while the fetch is in flight so PC may move on.
      assign imem_addr  = (state == S_WAIT) ? fa : PC[ADDR_W+1:2];

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= S_IDLE;
          cnt   <= 3'd0;
          fa    <= '0;
          busy  <= 1'b0;
          IR    <= NOP;
        end else begin
          case (state)
            S_IDLE: if (IR_Write) begin
              fa    <= PC[ADDR_W+1:2];
              cnt   <= 3'(IMEM_LAT);
              busy  <= 1'b1;
              state <= S_WAIT;
            end
            S_WAIT: if (cnt == 3'd1) begin
              IR    <= imem_rdata;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt - 3'd1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  endgenerate

endmodule
